inst_sequencer: RTL

INST_SEQUENCER -- requirements
Module: inst_sequencer

---
 rtl/core_pkg.sv | 44 ++++
 rtl/acc_addr_gen.sv | 33 +++
 rtl/inst_sequencer.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared constants, instruction-word field map and sequencer state encoding
// for the convolution core's instruction sequencer.
package core_pkg;

    localparam int          LEN_NIJ  = 36;
    localparam int          LEN_KIJ  = 9;
    localparam int          LEN_ONIJ = 16;
    localparam int          ROW      = 8;
    localparam int          COL      = 8;
    localparam logic [10:0] W_BASE   = 11'h400;

    // Edge lengths of the square input tile, output tile and kernel
    localparam int NIJ_SIDE  = 6;
    localparam int ONIJ_SIDE = 4;
    localparam int KIJ_SIDE  = 3;

    localparam int INST_W       = 37;
    localparam int ADDR_W       = 11;
    localparam int ACT_W        = 3;
    localparam int ACT_LSB      = 34;
    localparam int ACC_BIT      = 33;
    localparam int CEN_PMEM_BIT = 32;
    localparam int WEN_PMEM_BIT = 31;
    localparam int A_PMEM_LSB   = 20;
    localparam int CEN_XMEM_BIT = 19;
    localparam int WEN_XMEM_BIT = 18;
    localparam int A_XMEM_LSB   = 7;
    localparam int OFIFO_RD_BIT = 6;
    localparam int IFIFO_WR_BIT = 5;
    localparam int IFIFO_RD_BIT = 4;
    localparam int L0_RD_BIT    = 3;
    localparam int L0_WR_BIT    = 2;
    localparam int EXECUTE_BIT  = 1;
    localparam int LOAD_BIT     = 0;

    // Both memories disabled and write-inhibited (active-low strobes), all else quiet
    localparam logic [INST_W-1:0] INST_IDLE = (37'd1 << CEN_PMEM_BIT) | (37'd1 << WEN_PMEM_BIT)
                                            | (37'd1 << CEN_XMEM_BIT) | (37'd1 << WEN_XMEM_BIT);

    typedef enum logic [3:0] {
        IDLE, CLR, W_L0, W_PE, X_L0, EXEC, OF_RD, GAP, ACC_RST, ACC_RD, ACC_OUT, DONE
    } state_t;

endpackage

// File: rtl/acc_addr_gen.sv
// Registered psum address generator: pmem address of the partial sum for
// output pixel o under kernel tap k, one cycle after (o,k) is presented.
module acc_addr_gen
    import core_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  o,
    input  logic [3:0]  k,
    output logic [10:0] addr
);

    logic [10:0] addr_next;
    logic [10:0] addr_reg;

    // Tap k shifts the output pixel's window by (k/3, k%3) inside the 6x6 tile
    always_comb begin
        addr_next = 11'(LEN_NIJ) * 11'(k)
                  + (11'(o / 4'(ONIJ_SIDE)) + 11'(k / 4'(KIJ_SIDE))) * 11'(NIJ_SIDE)
                  + 11'(o % 4'(ONIJ_SIDE)) + 11'(k % 4'(KIJ_SIDE));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_reg <= '0;
        end else begin
            addr_reg <= addr_next;
        end
    end

    assign addr = addr_reg;

endmodule

// File: rtl/inst_sequencer.sv
// Instruction sequencer: walks the nine kernel taps (weight load, activation
// load, execute, psum drain) and then accumulates the sixteen output pixels.
module inst_sequencer #(
    parameter int          LEN_NIJ  = core_pkg::LEN_NIJ,
    parameter int          LEN_KIJ  = core_pkg::LEN_KIJ,
    parameter int          LEN_ONIJ = core_pkg::LEN_ONIJ,
    parameter int          ROW      = core_pkg::ROW,
    parameter int          COL      = core_pkg::COL,
    parameter logic [10:0] W_BASE   = core_pkg::W_BASE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  act_sel,
    input  logic        ofifo_valid,
    output logic [36:0] inst,
    output logic        core_rst,
    output logic        busy,
    output logic        done,
    output logic        out_valid,
    output logic [3:0]  out_idx
);

    localparam logic [6:0] CLR_LAST  = 7'd1;
    localparam logic [6:0] W_LAST    = 7'(COL - 1);
    localparam logic [6:0] NIJ_LAST  = 7'(LEN_NIJ - 1);
    localparam logic [6:0] EXEC_LAST = 7'(LEN_NIJ + ROW + COL - 1);
    localparam logic [3:0] KIJ_LAST  = 4'(LEN_KIJ - 1);
    localparam logic [3:0] ONIJ_LAST = 4'(LEN_ONIJ - 1);
    localparam logic [3:0] ACC_LAST  = 4'(LEN_KIJ);

    core_pkg::state_t state_reg, state_next;
    core_pkg::state_t ret_reg, ret_next;
    logic [6:0]  cnt_reg, cnt_next;
    logic [3:0]  k_reg, k_next;
    logic [3:0]  o_reg, o_next;
    logic [3:0]  j_reg, j_next;
    logic [2:0]  act_reg, act_next;
    logic [36:0] inst_reg, inst_next;
    logic        core_rst_reg, core_rst_next;
    logic        busy_reg, busy_next;
    logic        done_reg, done_next;
    logic        out_valid_reg, out_valid_next;
    logic [3:0]  out_idx_reg, out_idx_next;
    logic [10:0] acc_addr;

    // Fed with next-cycle (o,j) so its registered output lines up with ACC_RD
    acc_addr_gen u_addr_gen (
        .clk   (clk),
        .reset (reset),
        .o     (o_next),
        .k     (j_next),
        .addr  (acc_addr)
    );

    always_comb begin
        state_next     = state_reg;
        ret_next       = ret_reg;
        cnt_next       = cnt_reg;
        k_next         = k_reg;
        o_next         = o_reg;
        j_next         = j_reg;
        act_next       = act_reg;
        inst_next      = core_pkg::INST_IDLE;
        core_rst_next  = 1'b0;
        busy_next      = (state_reg != core_pkg::IDLE) && (state_reg != core_pkg::DONE);
        done_next      = 1'b0;
        out_valid_next = 1'b0;
        out_idx_next   = '0;

        if (busy_next) begin
            inst_next[core_pkg::ACT_LSB +: core_pkg::ACT_W] = act_reg;
        end

        case (state_reg)
            core_pkg::IDLE: begin
                if (start) begin
                    act_next   = act_sel;
                    cnt_next   = '0;
                    k_next     = '0;
                    o_next     = '0;
                    j_next     = '0;
                    state_next = core_pkg::CLR;
                end
            end
            core_pkg::CLR: begin
                core_rst_next = 1'b1;
                if (cnt_reg == CLR_LAST) begin
                    cnt_next   = '0;
                    state_next = core_pkg::W_L0;
                end else begin
                    cnt_next = cnt_reg + 7'd1;
                end
            end
            core_pkg::W_L0: begin
                inst_next[core_pkg::CEN_XMEM_BIT] = 1'b0;
                inst_next[core_pkg::L0_WR_BIT]    = 1'b1;
                inst_next[core_pkg::A_XMEM_LSB +: core_pkg::ADDR_W] =
                    W_BASE + 11'(COL) * 11'(k_reg) + 11'(cnt_reg);
                if (cnt_reg == W_LAST) begin
                    cnt_next   = '0;
                    ret_next   = core_pkg::W_PE;
                    state_next = core_pkg::GAP;
                end else begin
                    cnt_next = cnt_reg + 7'd1;
                end
            end
            core_pkg::W_PE: begin
                inst_next[core_pkg::L0_RD_BIT] = 1'b1;
                inst_next[core_pkg::LOAD_BIT]  = 1'b1;
                if (cnt_reg == W_LAST) begin
                    cnt_next   = '0;
                    ret_next   = core_pkg::X_L0;
                    state_next = core_pkg::GAP;
                end else begin
                    cnt_next = cnt_reg + 7'd1;
                end
            end
            core_pkg::X_L0: begin
                inst_next[core_pkg::CEN_XMEM_BIT] = 1'b0;
                inst_next[core_pkg::L0_WR_BIT]    = 1'b1;
                inst_next[core_pkg::A_XMEM_LSB +: core_pkg::ADDR_W] = 11'(cnt_reg);
                if (cnt_reg == NIJ_LAST) begin
                    cnt_next   = '0;
                    ret_next   = core_pkg::EXEC;
                    state_next = core_pkg::GAP;
                end else begin
                    cnt_next = cnt_reg + 7'd1;
                end
            end
            core_pkg::EXEC: begin
                inst_next[core_pkg::L0_RD_BIT]   = 1'b1;
                inst_next[core_pkg::EXECUTE_BIT] = 1'b1;
                if (cnt_reg == EXEC_LAST) begin
                    cnt_next   = '0;
                    ret_next   = core_pkg::OF_RD;
                    state_next = core_pkg::GAP;
                end else begin
                    cnt_next = cnt_reg + 7'd1;
                end
            end
            core_pkg::GAP: begin
                state_next = ret_reg;
            end
            core_pkg::OF_RD: begin
                // Drain only when the OFIFO has a row; otherwise hold the psum index
                if (ofifo_valid) begin
                    inst_next[core_pkg::OFIFO_RD_BIT] = 1'b1;
                    inst_next[core_pkg::CEN_PMEM_BIT] = 1'b0;
                    inst_next[core_pkg::WEN_PMEM_BIT] = 1'b0;
                    inst_next[core_pkg::A_PMEM_LSB +: core_pkg::ADDR_W] =
                        11'(LEN_NIJ) * 11'(k_reg) + 11'(cnt_reg);
                    if (cnt_reg == NIJ_LAST) begin
                        cnt_next = '0;
                        if (k_reg == KIJ_LAST) begin
                            o_next     = '0;
                            state_next = core_pkg::ACC_RST;
                        end else begin
                            k_next     = k_reg + 4'd1;
                            state_next = core_pkg::CLR;
                        end
                    end else begin
                        cnt_next = cnt_reg + 7'd1;
                    end
                end
            end
            core_pkg::ACC_RST: begin
                core_rst_next = 1'b1;
                j_next        = '0;
                state_next    = core_pkg::ACC_RD;
            end
            core_pkg::ACC_RD: begin
                // Final step reads nothing; it only accumulates the last tap's data
                if (j_reg != ACC_LAST) begin
                    inst_next[core_pkg::CEN_PMEM_BIT] = 1'b0;
                    inst_next[core_pkg::A_PMEM_LSB +: core_pkg::ADDR_W] = acc_addr;
                end
                inst_next[core_pkg::ACC_BIT] = (j_reg != 4'd0);
                if (j_reg == ACC_LAST) begin
                    state_next = core_pkg::ACC_OUT;
                end else begin
                    j_next = j_reg + 4'd1;
                end
            end
            core_pkg::ACC_OUT: begin
                out_valid_next = 1'b1;
                out_idx_next   = o_reg;
                if (o_reg == ONIJ_LAST) begin
                    state_next = core_pkg::DONE;
                end else begin
                    o_next     = o_reg + 4'd1;
                    state_next = core_pkg::ACC_RST;
                end
            end
            core_pkg::DONE: begin
                done_next  = 1'b1;
                state_next = core_pkg::IDLE;
            end
            default: begin
                state_next = core_pkg::IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= core_pkg::IDLE;
            ret_reg       <= core_pkg::IDLE;
            cnt_reg       <= '0;
            k_reg         <= '0;
            o_reg         <= '0;
            j_reg         <= '0;
            act_reg       <= '0;
            inst_reg      <= core_pkg::INST_IDLE;
            core_rst_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            out_valid_reg <= 1'b0;
            out_idx_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            ret_reg       <= ret_next;
            cnt_reg       <= cnt_next;
            k_reg         <= k_next;
            o_reg         <= o_next;
            j_reg         <= j_next;
            act_reg       <= act_next;
            inst_reg      <= inst_next;
            core_rst_reg  <= core_rst_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
            out_valid_reg <= out_valid_next;
            out_idx_reg   <= out_idx_next;
        end
    end

    assign inst      = inst_reg;
    assign core_rst  = core_rst_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign out_valid = out_valid_reg;
    assign out_idx   = out_idx_reg;

endmodule
